// File: rtl/riscv_immenc.sv
// RISC-V immediate encoder: scatters a flat immediate into a base instruction's format bits.
// Two-stage valid/ready pipeline; optional range checking via `IMMENC_RANGE_CHECK_EN`.
module riscv_immenc #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_imm,
    input  logic [2:0]      i_imm_src,
    input  logic [XLEN-1:0] i_base_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_instr,
    output logic            o_err,
    output logic [7:0]      o_err_cnt
);
    localparam logic [2:0] SRC_IMM_I = 3'd0;
    localparam logic [2:0] SRC_IMM_S = 3'd1;
    localparam logic [2:0] SRC_IMM_B = 3'd2;
    localparam logic [2:0] SRC_IMM_U = 3'd3;
    localparam logic [2:0] SRC_IMM_J = 3'd4;

    logic            r_a_valid;
    logic [XLEN-1:0] r_a_imm;
    logic [2:0]      r_a_src;
    logic [XLEN-1:0] r_a_base;
    logic            r_b_valid;
    logic [XLEN-1:0] r_b_instr;
    logic            r_b_err;
    logic [7:0]      r_err_cnt;

    logic            w_b_load;
    logic            w_a_load;
    logic            w_out_xfer;
    logic [XLEN-1:0] w_enc;
    logic            w_err;
    logic            w_range_ok;

    assign w_out_xfer = r_b_valid && i_ready;
    assign w_b_load   = !r_b_valid || w_out_xfer;
    assign w_a_load   = !r_a_valid || w_b_load;
    assign o_ready    = w_a_load;
    assign o_valid    = r_b_valid;
    assign o_instr    = r_b_instr;
    assign o_err      = r_b_err;
    assign o_err_cnt  = r_err_cnt;

`ifdef IMMENC_RANGE_CHECK_EN
    // True when v is the sign extension of its low n bits.
    function automatic logic sext_ok(input logic [XLEN-1:0] v, input int unsigned n);
        logic [XLEN-1:0] t;
        t = XLEN'($signed(v) >>> (n - 1));
        return (t == '0) || (t == '1);
    endfunction

    always_comb begin
        w_range_ok = 1'b1;
        case (r_a_src)
            SRC_IMM_I, SRC_IMM_S: w_range_ok = sext_ok(r_a_imm, 12);
            SRC_IMM_B:            w_range_ok = sext_ok(r_a_imm, 13) && !r_a_imm[0];
            SRC_IMM_U:            w_range_ok = (r_a_imm[11:0] == 12'd0);
            SRC_IMM_J:            w_range_ok = sext_ok(r_a_imm, 21) && !r_a_imm[0];
            default:              w_range_ok = 1'b1;
        endcase
    end
`else
    assign w_range_ok = 1'b1;
`endif

    // Every immediate position of the format is overwritten, so the old field bits are cleared.
    always_comb begin
        w_enc = r_a_base;
        w_err = !w_range_ok;
        case (r_a_src)
            SRC_IMM_I: w_enc[31:20] = r_a_imm[11:0];
            SRC_IMM_S: begin
                w_enc[31:25] = r_a_imm[11:5];
                w_enc[11:7]  = r_a_imm[4:0];
            end
            SRC_IMM_B: begin
                w_enc[31]    = r_a_imm[12];
                w_enc[30:25] = r_a_imm[10:5];
                w_enc[11:8]  = r_a_imm[4:1];
                w_enc[7]     = r_a_imm[11];
            end
            SRC_IMM_U: w_enc[31:12] = r_a_imm[31:12];
            SRC_IMM_J: begin
                w_enc[31]    = r_a_imm[20];
                w_enc[30:21] = r_a_imm[10:1];
                w_enc[20]    = r_a_imm[11];
                w_enc[19:12] = r_a_imm[19:12];
            end
            default:   w_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_valid <= 1'b0;
            r_a_imm   <= '0;
            r_a_src   <= '0;
            r_a_base  <= '0;
            r_b_valid <= 1'b0;
            r_b_instr <= '0;
            r_b_err   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_a_load) begin
                r_a_valid <= i_valid;
                if (i_valid) begin
                    r_a_imm  <= i_imm;
                    r_a_src  <= i_imm_src;
                    r_a_base <= i_base_instr;
                end
            end
            if (w_b_load) begin
                r_b_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_b_instr <= w_enc;
                    r_b_err   <= w_err;
                end
            end
            if (w_out_xfer && r_b_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_riscv_immenc.sv
// Randomized self-checking bench for riscv_immenc with a queue-based reference model.
// Honors `IMMENC_RANGE_CHECK_EN` in the model when the build defines it.
module tb_riscv_immenc;
    localparam logic [2:0] I = 3'd0, S = 3'd1, B = 3'd2, U = 3'd3, J = 3'd4;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_err;
    logic [31:0] i_imm, i_base_instr, o_instr;
    logic [2:0]  i_imm_src;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    riscv_immenc #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_imm(i_imm), .i_imm_src(i_imm_src), .i_base_instr(i_base_instr),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
        .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          t;
    } ent_t;

    ent_t q[$];
    int   cyc   = 0;
    int   cnt_m = 0;
    bit   armed = 1'b0;
    int   vec   = 0;
    int   bad   = 0;
    bit   m_ov, m_rd;
    logic [31:0] m_instr;
    logic        m_err;

    // Reference: clear the format's field mask, OR in the immediate assembled by concatenation.
    function automatic void model(input logic [31:0] imm, input logic [2:0] src,
                                  input logic [31:0] base,
                                  output logic [31:0] instr, output logic err);
        logic [31:0] mask, fld;
        int s;
        bit ok;
        s  = $signed(imm);
        ok = 1'b1;
        err = 1'b0;
        case (src)
            I: begin mask = 32'hFFF0_0000; fld = {imm[11:0], 20'b0};
                     ok = (s >= -2048) && (s <= 2047); end
            S: begin mask = 32'hFE00_0F80; fld = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                     ok = (s >= -2048) && (s <= 2047); end
            B: begin mask = 32'hFE00_0F80; fld = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                     ok = (s >= -4096) && (s <= 4095) && !imm[0]; end
            U: begin mask = 32'hFFFF_F000; fld = {imm[31:12], 12'b0};
                     ok = (imm[11:0] == 12'd0); end
            J: begin mask = 32'hFFFF_F000; fld = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                     ok = (s >= -(1 << 20)) && (s < (1 << 20)) && !imm[0]; end
            default: begin mask = 32'h0; fld = 32'h0; err = 1'b1; end
        endcase
`ifdef IMMENC_RANGE_CHECK_EN
        if (!ok) err = 1'b1;
`endif
        instr = (base & ~mask) | fld;
    endfunction

    // Front entry is visible once it was accepted before the most recent edge.
    function automatic bit exp_ovalid();
        return (q.size() > 0) && (q[0].t < cyc - 1);
    endfunction

    function automatic bit exp_oready();
        return (q.size() < 2) || (i_ready === 1'b1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (i_rst === 1'b1) begin
            q.delete();
            cnt_m = 0;
            armed = 1'b1;
        end else if (armed) begin
            m_ov = exp_ovalid();
            m_rd = exp_oready();
            if (m_ov && i_ready) begin
                if (q[0].err && cnt_m < 255) cnt_m++;
                void'(q.pop_front());
            end
            if (i_valid && m_rd) begin
                model(i_imm, i_imm_src, i_base_instr, m_instr, m_err);
                q.push_back('{m_instr, m_err, cyc});
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        #2;
        if (armed) begin
            chk("o_ready", 32'(o_ready), 32'(exp_oready()));
            chk("o_valid", 32'(o_valid), 32'(exp_ovalid()));
            if (exp_ovalid()) begin
                chk("o_instr", o_instr, q[0].instr);
                chk("o_err", 32'(o_err), 32'(q[0].err));
            end
            chk("o_err_cnt", 32'(o_err_cnt), 32'(cnt_m));
        end
    end

    task automatic send(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_imm = imm; i_imm_src = src; i_base_instr = base;
        for (int k = 0; k < 64; k++) begin
            #1;
            acc = o_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) begin
            vec++; bad++;
            $display("FAIL accept_timeout: got o_ready=0 for 64 cycles expected 1");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return r;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return {{11{r[20]}}, r[20:1], 1'b0};
            default: return r & 32'hFFFF_F000;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pi;
        logic        pe;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_imm = '0; i_imm_src = '0; i_base_instr = '0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;

        // Hand-computed pins on the model itself.
        model(32'hFFFF_FFFF, I, 32'h0000_0013, pi, pe);
        chk("pin_I", pi, 32'hFFF0_0013); chk("pin_I_err", 32'(pe), 32'd0);
        model(32'h0000_0024, S, 32'h0000_2023, pi, pe); chk("pin_S", pi, 32'h0200_2223);
        model(32'h0000_0008, B, 32'h0000_0063, pi, pe); chk("pin_B", pi, 32'h0000_0463);
        model(32'h1234_5000, U, 32'h0000_0037, pi, pe); chk("pin_U", pi, 32'h1234_5037);
        model(32'h0000_0003, J, 32'h0000_006F, pi, pe);
`ifdef IMMENC_RANGE_CHECK_EN
        chk("pin_J_err", 32'(pe), 32'd1);
`else
        chk("pin_J_err", 32'(pe), 32'd0);
`endif
        model(32'h0000_0005, 3'd6, 32'hDEAD_BEEF, pi, pe);
        chk("pin_unk", pi, 32'hDEAD_BEEF); chk("pin_unk_err", 32'(pe), 32'd1);

        // Directed vectors with downstream always ready.
        @(negedge clk); i_ready = 1'b1;
        send(32'hFFFF_FFFF, I, 32'h0000_0013);
        idle(); repeat (3) @(negedge clk);
        chk("lat_I_instr", o_instr, 32'hFFF0_0013);
        send(32'h0000_0024, S, 32'h0000_2023);
        send(32'h0000_0008, B, 32'h0000_0063);
        send(32'h1234_5000, U, 32'h0000_0037);
        send(32'h0000_0003, J, 32'h0000_006F);
        idle(); repeat (4) @(negedge clk);

        // Backpressure: three requests while downstream stalls, then release.
        i_ready = 1'b0;
        fork
            begin
                send(32'h0000_0100, I, 32'h0000_0093);
                send(32'h0000_0ABC, S, 32'h0000_A023);
                send(32'h0000_0FFE, B, 32'h0000_1063);
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                i_ready = 1'b1;
            end
        join
        repeat (5) @(negedge clk);

        // Reset with both stages full.
        i_ready = 1'b0;
        send(32'h0000_0001, 3'd7, 32'h1111_1111);
        send(32'h0000_0002, 3'd5, 32'h2222_2222);
        idle();
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        #2;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);

        // Random traffic with random backpressure.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            i_valid      = ($urandom_range(0, 3) != 0);
            i_ready      = ($urandom_range(0, 3) != 0);
            i_imm        = rnd_imm();
            i_imm_src    = 3'($urandom_range(0, 7));
            i_base_instr = $urandom;
        end
        idle(); i_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Saturate the error counter.
        i_rst = 1'b1; @(negedge clk); i_rst = 1'b0;
        for (int n = 0; n < 300; n++)
            send($urandom, 3'(5 + $urandom_range(0, 2)), $urandom);
        idle(); repeat (4) @(negedge clk);
        #2;
        chk("sat_o_err_cnt", 32'(o_err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/riscv_immenc.md
RISCV_IMMENC -- requirements
Module: riscv_immenc

Interface
REQ-001 i_clk  input  1  system clock; all state updates on rising edge.
REQ-002 i_rst  input  1  reset, synchronous and active-high.
REQ-003 i_valid  input  1  upstream request valid.
REQ-004 o_ready  output  1  block can accept a request this cycle.
REQ-005 i_imm  input  XLEN  immediate value, full-width two's complement byte offset or value.
REQ-006 i_imm_src  input  3  immediate format, coded with the codebase `SRC_IMM_I/S/B/U/J` values.
REQ-007 i_base_instr  input  XLEN  instruction word whose non-immediate fields are kept.
REQ-008 o_valid  output  1  encoded instruction valid.
REQ-009 i_ready  input  1  downstream accepts the output this cycle.
REQ-010 o_instr  output  XLEN  base instruction with the immediate scattered into its format bit positions.
REQ-011 o_err  output  1  error flag aligned with o_instr.
REQ-012 o_err_cnt  output  8  saturating count of erroneous outputs handed downstream.

Function
REQ-013 Transfer occurs on i_valid&&o_ready at input and o_valid&&i_ready at output.
REQ-014 Two-stage pipeline: stage A (input capture), stage B (output register); latency 2 cycles with no stall.
REQ-015 Stage B loads when empty or when the downstream transfer happens that cycle.
REQ-016 Stage A loads when empty or when it advances into B that cycle.
REQ-017 o_ready = !A_valid || B_loads, computed combinationally; throughput 1 per cycle when i_ready is held high.
REQ-018 While o_valid=1 and i_ready=0, o_instr, o_err and o_valid hold stable.
REQ-019 Stage A latches i_imm, i_imm_src and i_base_instr unmodified.
REQ-020 Encoding is combinational between A and B.
REQ-021 Bits in the format's immediate positions of i_base_instr are cleared before the immediate is merged.
REQ-022 I-type: instr[31:20]=imm[11:0].
REQ-023 S-type: instr[31:25]=imm[11:5]; instr[11:7]=imm[4:0].
REQ-024 B-type: instr[31]=imm[12]; instr[7]=imm[11]; instr[30:25]=imm[10:5]; instr[11:8]=imm[4:1].
REQ-025 U-type: instr[31:12]=imm[31:12].
REQ-026 J-type: instr[31]=imm[20]; instr[19:12]=imm[19:12]; instr[20]=imm[11]; instr[30:21]=imm[10:1].
REQ-027 Unknown i_imm_src code: o_instr = i_base_instr unchanged and o_err=1.
REQ-028 o_err_cnt increments by 1 on each output transfer with o_err=1, saturating at 255 (no wrap).
REQ-029 Simultaneous input and output transfer with both stages full is legal and loses no data.

Reset
REQ-030 On i_rst=1 at a clock edge: both stage valids, o_valid, o_err and o_err_cnt become 0; stage data registers become 0.
REQ-031 Reset asserted mid-stream discards in-flight entries; o_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro IMMENC_RANGE_CHECK_EN.
REQ-033 Defined: o_err is also set on any range violation; o_instr is still produced from the truncated bits.
REQ-034 Range rules: I/S require imm to be a sign-extended 12-bit value; B requires sign-extended 13-bit with imm[0]=0; U requires imm[11:0]=0; J requires sign-extended 21-bit with imm[0]=0.
REQ-035 Undefined: the range-check logic is absent, and o_err is set only for unknown i_imm_src codes.

Verification
REQ-036 I-type, imm=0xFFFFFFFF, base=0x00000013, i_ready=1 -> o_instr=0xFFF00013, o_err=0, o_valid 2 cycles after accept.
REQ-037 S-type, imm=0x00000024, base=0x00002023 -> o_instr=0x02002223; B-type, imm=0x00000008, base=0x00000063 -> o_instr=0x00000463.
REQ-038 U-type, imm=0x12345000, base=0x00000037 -> o_instr=0x12345037; J-type, imm=0x00000003, with IMMENC_RANGE_CHECK_EN defined -> o_err=1, o_err_cnt 0->1; same stimulus without the macro -> o_err=0.
REQ-039 Three back-to-back requests with i_ready=0 for 4 cycles -> o_ready=0 after 2 accepts, o_instr held stable, then all 3 delivered in order once i_ready=1.
REQ-040 i_rst pulsed with both stages full -> o_valid=0 and o_err_cnt=0 the next cycle; 300 erroneous transfers -> o_err_cnt=255.
